mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-master, one-slave memory arbiter for the NPC core.
- The instruction-fetch unit (IFU, read-only) and the load/store unit (LSU, read/write with byte mask) share a single memory port through it. The slave side sits in front of the DPI memory model (npcmem_read/npcmem_write).
- One transaction is in flight at a time. Arbitration is round-robin. A response watchdog returns an error instead of hanging the core.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles in WAIT before an error response; legal range 1..65535

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-low (0 = reset)
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  IFU read address
- ifu_resp_valid  out  1  IFU response available
- ifu_resp_ready  in  1  IFU takes response
- ifu_rdata  out  DATA_W  IFU read data
- ifu_resp_err  out  1  IFU response is a timeout error
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  ADDR_W  LSU address
- lsu_wen  in  1  1 = write, 0 = read
- lsu_wdata  in  DATA_W  LSU write data
- lsu_wmask  in  8  LSU byte write mask
- lsu_resp_valid  out  1  LSU response available
- lsu_resp_ready  in  1  LSU takes response
- lsu_rdata  out  DATA_W  LSU read data (0 for writes)
- lsu_resp_err  out  1  LSU response is a timeout error
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  ADDR_W  memory address
- mem_wen  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_wmask  out  8  memory byte mask
- mem_resp_valid  in  1  memory response
- mem_resp_ready  out  1  arbiter takes memory response
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  state != IDLE or stale pending

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. Registers: state, owner (0 = IFU, 1 = LSU), last_lsu, stale, latched request (addr/wen/wdata/wmask), resp_data, resp_err, timeout counter (16 bit).
- Reset (rst = 0 at clock edge) forces:
  - state = IDLE, owner = 0, last_lsu = 0, stale = 0, counter = 0, resp_data = 0, resp_err = 0.
  - All valid/ready outputs and busy = 0; data outputs = 0.
  - Reset mid-transaction abandons the transaction silently.
- IDLE, stale = 0:
  - Arbitration is combinational. Only one requester: it is granted. Both requesting: grant LSU if last_lsu = 0, else IFU. After reset, LSU wins the first tie.
  - The granted master's req_ready = 1 in the same cycle. The other master's req_ready = 0.
  - On the edge, latch the request and set owner and last_lsu = owner. Go to ISSUE.
  - IFU grants latch wen = 0, wmask = 0, wdata = 0.
- IDLE, stale = 1: no req_ready. mem_resp_ready = 1. The first mem_resp_valid is discarded and clears stale.
- ISSUE:
  - mem_req_valid = 1, and mem_* are driven from the latched registers, stable until accepted.
  - On mem_req_ready go to WAIT with counter = 0.
  - No timeout in ISSUE.
- WAIT:
  - mem_resp_ready = 1.
  - On mem_resp_valid: resp_data = mem_rdata (forced 0 if latched wen = 1), resp_err = 0, go to RESP.
  - Otherwise counter increments. When counter == TIMEOUT-1 without a response: resp_data = 0, resp_err = 1, stale = 1, go to RESP.
  - A response arriving in the same cycle as expiry wins: no error, no stale.
- RESP:
  - The owner's resp_valid = 1 with rdata = resp_data and resp_err; the non-owner's resp_valid = 0.
  - On the owner's resp_ready go to IDLE. A new grant is possible the following cycle, not the same cycle.
  - While stale = 1, mem_resp_ready = 1 in RESP as well, with the same discard rule.
- Minimum latency: request accept at cycle N, mem_req_valid at N+1. If memory is ready at N+1 and responds at N+2, master resp_valid is at N+3. Throughput is at most one transaction per 4 cycles.
- mem_* outputs outside ISSUE: addr/wdata hold the latched values; mem_req_valid = 0.

Test Plan:
- Single IFU read 0x80000000; mem ready immediately, rdata 0x00100073 after 1 cycle -> ifu_resp_valid at cycle 3 with ifu_rdata 0x00100073, err 0; lsu_resp_valid stays 0.
- LSU write addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F -> mem sees wen = 1 and identical addr/data/mask; lsu_rdata = 0; IFU idle throughout.
- Both requesting continuously after reset -> grant order LSU, IFU, LSU, IFU; mem_addr alternates accordingly; no master starved.
- mem_req_ready held low 10 cycles, then responds -> mem_req_valid and mem_addr stable all 10 cycles; correct data returned, no error.
- TIMEOUT = 4, memory never responds -> lsu_resp_err = 1 and lsu_rdata = 0 four cycles after WAIT entry. New requests are blocked until a late mem_resp_valid is pulsed and discarded; the next IFU read then completes normally.
- rst driven low during WAIT -> next cycle all valids 0 and busy 0; a subsequent IFU request is granted normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave memory arbiter. One transaction
// in flight, round-robin on ties, and a watchdog that turns a silent slave into an error.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    input  logic              ifu_resp_ready,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic              ifu_resp_err,

    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [7:0]        lsu_wmask,
    output logic              lsu_resp_valid,
    input  logic              lsu_resp_ready,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_resp_err,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_resp_valid,
    output logic              mem_resp_ready,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [15:0] LAST_CNT = 16'(TIMEOUT - 1);

    state_t            r_state;
    logic              r_owner;
    logic              r_last_lsu;
    logic              r_stale;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wen;
    logic [DATA_W-1:0] r_wdata;
    logic [7:0]        r_wmask;
    logic [DATA_W-1:0] r_resp_data;
    logic              r_resp_err;
    logic [15:0]       r_cnt;

    logic w_grant;
    logic w_grant_lsu;
    logic w_owner_ready;

    always_comb begin
        w_grant       = rst && (r_state == IDLE) && !r_stale && (ifu_req_valid || lsu_req_valid);
        // On a tie the master that did not win last time goes first.
        w_grant_lsu   = lsu_req_valid && (!ifu_req_valid || !r_last_lsu);
        w_owner_ready = r_owner ? lsu_resp_ready : ifu_resp_ready;
    end

    assign ifu_req_ready  = w_grant && !w_grant_lsu;
    assign lsu_req_ready  = w_grant && w_grant_lsu;

    assign mem_req_valid  = (r_state == ISSUE);
    assign mem_addr       = r_addr;
    assign mem_wen        = r_wen;
    assign mem_wdata      = r_wdata;
    assign mem_wmask      = r_wmask;
    // A stale response from a timed-out transaction is still accepted and dropped.
    assign mem_resp_ready = (r_state == WAIT) || r_stale;

    assign ifu_resp_valid = (r_state == RESP) && !r_owner;
    assign lsu_resp_valid = (r_state == RESP) && r_owner;
    assign ifu_rdata      = r_owner ? '0 : r_resp_data;
    assign lsu_rdata      = r_owner ? r_resp_data : '0;
    assign ifu_resp_err   = r_resp_err && !r_owner;
    assign lsu_resp_err   = r_resp_err && r_owner;

    assign busy           = (r_state != IDLE) || r_stale;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_owner     <= 1'b0;
            r_last_lsu  <= 1'b0;
            r_stale     <= 1'b0;
            r_addr      <= '0;
            r_wen       <= 1'b0;
            r_wdata     <= '0;
            r_wmask     <= '0;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
            r_cnt       <= '0;
        end else begin
            if (r_stale && mem_resp_valid)
                r_stale <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_owner    <= w_grant_lsu;
                        r_last_lsu <= w_grant_lsu;
                        r_addr     <= w_grant_lsu ? lsu_addr : ifu_addr;
                        r_wen      <= w_grant_lsu && lsu_wen;
                        r_wdata    <= w_grant_lsu ? lsu_wdata : '0;
                        r_wmask    <= w_grant_lsu ? lsu_wmask : '0;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        r_cnt   <= '0;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    // A response in the expiry cycle takes priority over the error.
                    if (mem_resp_valid) begin
                        r_resp_data <= r_wen ? '0 : mem_rdata;
                        r_resp_err  <= 1'b0;
                        r_state     <= RESP;
                    end else if (r_cnt == LAST_CNT) begin
                        r_resp_data <= '0;
                        r_resp_err  <= 1'b1;
                        r_stale     <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                RESP: begin
                    if (w_owner_ready)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run checked against a
// transaction-level model (one outstanding request, round-robin, reference memory).
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [7:0]  wmask;
    } txn_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_resp_err;
    logic [AW-1:0] ifu_addr;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata, lsu_rdata;
    logic [7:0]    lsu_wmask;
    logic          mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [7:0]    mem_wmask;
    logic          busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
        .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
        .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifu_req_valid = 0; ifu_addr = '0; ifu_resp_ready = 0;
        lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
        lsu_resp_ready = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        tick(); idle_inputs(); rst = 0;
        tick();
        tick(); rst = 1;
    endtask

    task automatic drain();
        logic pend = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            ifu_req_valid = 0; lsu_req_valid = 0; ifu_resp_ready = 1; lsu_resp_ready = 1;
            mem_resp_valid = pend; pend = 1'b0;
            mem_req_ready = mem_req_valid;
            if (mem_req_valid) pend = 1'b1;
        end
        tick(); idle_inputs();
    endtask

    task automatic test_reset();
        tick(); idle_inputs(); rst = 0;
        ifu_req_valid = 1; lsu_req_valid = 1; ifu_resp_ready = 1; lsu_resp_ready = 1;
        ifu_addr = 32'h8000_0000; lsu_addr = 32'h8000_1000; mem_resp_valid = 1;
        tick(); #1;
        n_chk++;
        if ({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid,
             mem_req_valid, mem_resp_ready, busy} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, expected 0000000", {ifu_req_ready, lsu_req_ready,
                     ifu_resp_valid, lsu_resp_valid, mem_req_valid, mem_resp_ready, busy});
        end
        n_chk++;
        if ({mem_addr, mem_wdata, mem_wmask, mem_wen, ifu_rdata, lsu_rdata, ifu_resp_err,
             lsu_resp_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%h wdata=%h ifu_rdata=%h lsu_rdata=%h, expected all 0",
                     mem_addr, mem_wdata, ifu_rdata, lsu_rdata);
        end
        tick(); idle_inputs(); rst = 1;
    endtask

    task automatic test_ifu_read();
        tick(); ifu_req_valid = 1; ifu_addr = 32'h8000_0000; ifu_resp_ready = 1; #1;
        n_chk++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
            n_fail++; $display("FAIL ifu_grant: got %b, expected 10", {ifu_req_ready, lsu_req_ready});
        end
        tick(); ifu_req_valid = 0; ifu_addr = '0; mem_req_ready = 1; #1;
        n_chk++;
        if ({mem_req_valid, mem_addr, mem_wen} !== {1'b1, 32'h8000_0000, 1'b0}) begin
            n_fail++; $display("FAIL ifu_issue: valid=%b addr=%h wen=%b, expected 1 80000000 0",
                               mem_req_valid, mem_addr, mem_wen);
        end
        tick(); mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h0010_0073; #1;
        n_chk++;
        if ({mem_resp_ready, ifu_resp_valid, mem_req_valid} !== 3'b100) begin
            n_fail++; $display("FAIL ifu_wait: got %b, expected 100",
                               {mem_resp_ready, ifu_resp_valid, mem_req_valid});
        end
        tick(); mem_resp_valid = 0; mem_rdata = '0; #1;
        n_chk++;
        if ({ifu_resp_valid, lsu_resp_valid, ifu_resp_err, ifu_rdata} !==
            {1'b1, 1'b0, 1'b0, 32'h0010_0073}) begin
            n_fail++; $display("FAIL ifu_resp: v=%b lv=%b err=%b data=%h, expected 1 0 0 00100073",
                               ifu_resp_valid, lsu_resp_valid, ifu_resp_err, ifu_rdata);
        end
        tick(); ifu_resp_ready = 0; #1;
        n_chk++;
        if ({ifu_resp_valid, busy} !== 2'b00) begin
            n_fail++; $display("FAIL ifu_done: got %b, expected 00", {ifu_resp_valid, busy});
        end
    endtask

    task automatic test_lsu_write();
        tick(); lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 8'h0F; lsu_resp_ready = 1; #1;
        n_chk++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin
            n_fail++; $display("FAIL wr_grant: got %b, expected 01", {ifu_req_ready, lsu_req_ready});
        end
        tick(); lsu_req_valid = 0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0; mem_req_ready = 1; #1;
        n_chk++;
        if ({mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask} !==
            {1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 8'h0F}) begin
            n_fail++; $display("FAIL wr_issue: v=%b addr=%h wen=%b wdata=%h mask=%h, expected 1 80001000 1 deadbeef 0f",
                               mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask);
        end
        tick(); mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h1234_5678; #1;
        n_chk++;
        if ({mem_resp_ready, lsu_resp_valid, ifu_req_ready, ifu_resp_valid} !== 4'b1000) begin
            n_fail++; $display("FAIL wr_wait: got %b, expected 1000",
                               {mem_resp_ready, lsu_resp_valid, ifu_req_ready, ifu_resp_valid});
        end
        tick(); mem_resp_valid = 0; mem_rdata = '0; #1;
        n_chk++;
        if ({lsu_resp_valid, ifu_resp_valid, lsu_resp_err, lsu_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            n_fail++; $display("FAIL wr_resp: v=%b iv=%b err=%b data=%h, expected 1 0 0 00000000",
                               lsu_resp_valid, ifu_resp_valid, lsu_resp_err, lsu_rdata);
        end
        tick(); lsu_resp_ready = 0; #1;
        n_chk++;
        if ({lsu_resp_valid, busy} !== 2'b00) begin
            n_fail++; $display("FAIL wr_done: got %b, expected 00", {lsu_resp_valid, busy});
        end
    endtask

    task automatic test_round_robin();
        logic        exp_lsu = 1'b1;
        logic        pend = 1'b0;
        logic [31:0] exp_addr = '0;
        int          got = 0;
        do_reset();
        for (int c = 0; c < 60 && got < 4; c++) begin
            tick();
            ifu_req_valid = 1; ifu_addr = 32'h8000_0100; ifu_resp_ready = 1;
            lsu_req_valid = 1; lsu_addr = 32'h8000_0200; lsu_wen = 0; lsu_resp_ready = 1;
            mem_resp_valid = pend; mem_rdata = 32'h0000_0013; pend = 1'b0;
            mem_req_ready = mem_req_valid;
            if (mem_req_valid) pend = 1'b1;
            #1;
            if (mem_req_valid) begin
                n_chk++;
                if (mem_addr !== exp_addr) begin
                    n_fail++; $display("FAIL rr_addr: got %h, expected %h", mem_addr, exp_addr);
                end
            end
            if (ifu_req_ready || lsu_req_ready) begin
                n_chk++;
                if (lsu_req_ready !== exp_lsu || ifu_req_ready === lsu_req_ready) begin
                    n_fail++; $display("FAIL rr_order: grant %0d lsu_ready=%b ifu_ready=%b, expected lsu=%b",
                                       got, lsu_req_ready, ifu_req_ready, exp_lsu);
                end
                exp_addr = exp_lsu ? 32'h8000_0200 : 32'h8000_0100;
                exp_lsu  = !exp_lsu;
                got++;
            end
        end
        n_chk++;
        if (got != 4) begin
            n_fail++; $display("FAIL rr_count: got %0d grants, expected 4", got);
        end
        drain();
    endtask

    task automatic test_stall();
        tick(); ifu_req_valid = 1; ifu_addr = 32'h8000_0040; ifu_resp_ready = 1; #1;
        n_chk++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
            n_fail++; $display("FAIL stall_grant: got %b, expected 10", {ifu_req_ready, lsu_req_ready});
        end
        for (int c = 0; c < 10; c++) begin
            tick(); ifu_req_valid = 0; ifu_addr = '0; #1;
            n_chk++;
            if ({mem_req_valid, mem_addr, ifu_resp_valid, ifu_resp_err} !==
                {1'b1, 32'h8000_0040, 1'b0, 1'b0}) begin
                n_fail++; $display("FAIL stall_hold: cycle %0d v=%b addr=%h rv=%b, expected 1 80000040 0",
                                   c, mem_req_valid, mem_addr, ifu_resp_valid);
            end
        end
        tick(); mem_req_ready = 1; #1;
        tick(); mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'hCAFE_F00D; #1;
        tick(); mem_resp_valid = 0; mem_rdata = '0; #1;
        n_chk++;
        if ({ifu_resp_valid, ifu_resp_err, ifu_rdata} !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin
            n_fail++; $display("FAIL stall_resp: v=%b err=%b data=%h, expected 1 0 cafef00d",
                               ifu_resp_valid, ifu_resp_err, ifu_rdata);
        end
        tick(); ifu_resp_ready = 0;
    endtask

    task automatic test_timeout();
        int first = -1;
        tick(); lsu_req_valid = 1; lsu_addr = 32'h8000_0080; lsu_wen = 0; lsu_resp_ready = 0; #1;
        n_chk++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin
            n_fail++; $display("FAIL to_grant: got %b, expected 01", {ifu_req_ready, lsu_req_ready});
        end
        tick(); lsu_req_valid = 0; mem_req_ready = 1; #1;
        for (int c = 1; c <= 12 && first < 0; c++) begin
            tick(); mem_req_ready = 0; #1;
            if (lsu_resp_valid) first = c;
        end
        n_chk++;
        if (first != TO + 1) begin
            n_fail++; $display("FAIL to_latency: resp at %0d cycles after accept, expected %0d", first, TO + 1);
        end
        n_chk++;
        if ({lsu_resp_err, lsu_rdata, ifu_resp_valid} !== {1'b1, 32'h0, 1'b0}) begin
            n_fail++; $display("FAIL to_err: err=%b data=%h iv=%b, expected 1 00000000 0",
                               lsu_resp_err, lsu_rdata, ifu_resp_valid);
        end
        tick(); lsu_resp_ready = 1; #1;
        for (int c = 0; c < 3; c++) begin
            tick(); lsu_resp_ready = 0; ifu_req_valid = 1; ifu_addr = 32'h8000_0004; ifu_resp_ready = 1; #1;
            n_chk++;
            if ({ifu_req_ready, lsu_resp_valid, busy, mem_resp_ready} !== 4'b0011) begin
                n_fail++; $display("FAIL to_blocked: got %b, expected 0011",
                                   {ifu_req_ready, lsu_resp_valid, busy, mem_resp_ready});
            end
        end
        tick(); mem_resp_valid = 1; mem_rdata = 32'h5555_5555; #1;
        n_chk++;
        if (ifu_req_ready !== 1'b0) begin
            n_fail++; $display("FAIL to_discard: ifu_req_ready=%b, expected 0", ifu_req_ready);
        end
        tick(); mem_resp_valid = 0; mem_rdata = '0; #1;
        n_chk++;
        if ({ifu_req_ready, ifu_resp_valid, lsu_resp_valid} !== 3'b100) begin
            n_fail++; $display("FAIL to_regrant: got %b, expected 100",
                               {ifu_req_ready, ifu_resp_valid, lsu_resp_valid});
        end
        tick(); ifu_req_valid = 0; mem_req_ready = 1; #1;
        n_chk++;
        if ({mem_req_valid, mem_addr} !== {1'b1, 32'h8000_0004}) begin
            n_fail++; $display("FAIL to_issue: v=%b addr=%h, expected 1 80000004", mem_req_valid, mem_addr);
        end
        tick(); mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h0BAD_F00D; #1;
        tick(); mem_resp_valid = 0; mem_rdata = '0; #1;
        n_chk++;
        if ({ifu_resp_valid, ifu_resp_err, ifu_rdata} !== {1'b1, 1'b0, 32'h0BAD_F00D}) begin
            n_fail++; $display("FAIL to_after: v=%b err=%b data=%h, expected 1 0 0badf00d",
                               ifu_resp_valid, ifu_resp_err, ifu_rdata);
        end
        tick(); ifu_resp_ready = 0;
    endtask

    task automatic test_reset_mid();
        tick(); lsu_req_valid = 1; lsu_addr = 32'h8000_00C0; lsu_wen = 0; lsu_resp_ready = 1; #1;
        tick(); lsu_req_valid = 0; mem_req_ready = 1; #1;
        tick(); mem_req_ready = 0; #1;
        n_chk++;
        if ({mem_resp_ready, busy} !== 2'b11) begin
            n_fail++; $display("FAIL rm_wait: got %b, expected 11", {mem_resp_ready, busy});
        end
        tick(); rst = 0; #1;
        tick(); rst = 1; #1;
        n_chk++;
        if ({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_req_valid,
             mem_resp_ready, busy} !== 7'b0) begin
            n_fail++; $display("FAIL rm_cleared: got %b, expected 0000000", {ifu_req_ready, lsu_req_ready,
                               ifu_resp_valid, lsu_resp_valid, mem_req_valid, mem_resp_ready, busy});
        end
        tick(); ifu_req_valid = 1; ifu_addr = 32'h8000_0010; ifu_resp_ready = 1; #1;
        n_chk++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
            n_fail++; $display("FAIL rm_grant: got %b, expected 10", {ifu_req_ready, lsu_req_ready});
        end
        tick(); ifu_req_valid = 0; mem_req_ready = 1; #1;
        tick(); mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h0000_1234; #1;
        tick(); mem_resp_valid = 0; #1;
        n_chk++;
        if ({ifu_resp_valid, ifu_resp_err, ifu_rdata} !== {1'b1, 1'b0, 32'h0000_1234}) begin
            n_fail++; $display("FAIL rm_resp: v=%b err=%b data=%h, expected 1 0 00001234",
                               ifu_resp_valid, ifu_resp_err, ifu_rdata);
        end
        tick(); idle_inputs();
    endtask

    task automatic test_random();
        logic [31:0] rmem [8];
        logic [31:0] smem [8];
        txn_t        seen_q[$];
        txn_t        exp_t = '0;
        logic [31:0] exp_rd = '0;
        logic [31:0] s_data = '0;
        logic        m_busy = 0, m_owner = 0, m_last_lsu = 0, ifu_gnt = 0, lsu_gnt = 0;
        logic        exp_l, exp_i, feed;
        int          s_ph = 0, s_dly = 0, idx, n_ifu = 0, n_lsu = 0;
        for (int i = 0; i < 8; i++) begin
            rmem[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
            smem[i] = rmem[i];
        end
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            feed = (c < 2400);
            tick();
            if (ifu_gnt) ifu_req_valid = 0;
            else if (feed && !ifu_req_valid && $urandom_range(0, 2) == 0) begin
                ifu_req_valid = 1;
                ifu_addr = 32'h8000_0000 + 32'($urandom_range(0, 7)) * 32'd4;
            end
            if (lsu_gnt) lsu_req_valid = 0;
            else if (feed && !lsu_req_valid && $urandom_range(0, 2) == 0) begin
                lsu_req_valid = 1;
                lsu_addr  = 32'h8000_0000 + 32'($urandom_range(0, 7)) * 32'd4;
                lsu_wen   = 1'($urandom_range(0, 1));
                lsu_wdata = $urandom;
                lsu_wmask = 8'($urandom);
            end
            ifu_resp_ready = ($urandom_range(0, 3) != 0);
            lsu_resp_ready = ($urandom_range(0, 3) != 0);
            // Memory: random accept delay, then a response 0..TO-1 cycles into WAIT.
            mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = $urandom;
            if (s_ph == 2) begin
                if (s_dly == 0) begin mem_resp_valid = 1; mem_rdata = s_data; s_ph = 0; end
                else s_dly--;
            end else if (mem_req_valid) begin
                if (s_ph == 0) begin s_ph = 1; s_dly = int'($urandom_range(0, 3)); end
                if (s_dly == 0) begin
                    mem_req_ready = 1;
                    seen_q.push_back('{mem_addr, mem_wen, mem_wdata, mem_wmask});
                    idx = int'(mem_addr[4:2]);
                    if (mem_wen) begin
                        for (int b = 0; b < 4; b++)
                            if (mem_wmask[b]) smem[idx][8*b +: 8] = mem_wdata[8*b +: 8];
                        s_data = $urandom;
                    end else s_data = smem[idx];
                    s_ph = 2; s_dly = int'($urandom_range(0, TO - 1));
                end else s_dly--;
            end
            #1;
            ifu_gnt = 0; lsu_gnt = 0;
            exp_l = !m_busy && lsu_req_valid && (!ifu_req_valid || !m_last_lsu);
            exp_i = !m_busy && ifu_req_valid && !exp_l;
            n_chk++;
            if ({ifu_req_ready, lsu_req_ready} !== {exp_i, exp_l}) begin
                n_fail++; $display("FAIL rand_grant: cycle %0d ready(i,l)=%b%b, expected %b%b",
                                   c, ifu_req_ready, lsu_req_ready, exp_i, exp_l);
            end
            if (exp_l || exp_i) begin
                m_busy = 1; m_owner = exp_l; m_last_lsu = exp_l; lsu_gnt = exp_l; ifu_gnt = exp_i;
                if (exp_l) exp_t = '{lsu_addr, lsu_wen, lsu_wdata, lsu_wmask};
                else       exp_t = '{ifu_addr, 1'b0, 32'h0, 8'h0};
                idx = int'(exp_t.addr[4:2]);
                if (exp_t.wen) begin
                    for (int b = 0; b < 4; b++)
                        if (exp_t.wmask[b]) rmem[idx][8*b +: 8] = exp_t.wdata[8*b +: 8];
                    exp_rd = '0;
                end else exp_rd = rmem[idx];
            end
            if (ifu_resp_valid || lsu_resp_valid) begin
                n_chk++;
                if (!m_busy || {ifu_resp_valid, lsu_resp_valid} !== (m_owner ? 2'b01 : 2'b10)) begin
                    n_fail++; $display("FAIL rand_owner: cycle %0d resp(i,l)=%b%b busy=%b owner=%b",
                                       c, ifu_resp_valid, lsu_resp_valid, m_busy, m_owner);
                end
                n_chk++;
                if ((m_owner ? lsu_rdata : ifu_rdata) !== exp_rd ||
                    (m_owner ? lsu_resp_err : ifu_resp_err) !== 1'b0) begin
                    n_fail++; $display("FAIL rand_data: cycle %0d data=%h err=%b, expected %h 0", c,
                                       m_owner ? lsu_rdata : ifu_rdata,
                                       m_owner ? lsu_resp_err : ifu_resp_err, exp_rd);
                end
                if (m_owner ? lsu_resp_ready : ifu_resp_ready) begin
                    n_chk++;
                    if (seen_q.size() != 1 || seen_q[0] !== exp_t) begin
                        n_fail++; $display("FAIL rand_memside: cycle %0d seen %0d txns, expected addr=%h wen=%b wdata=%h mask=%h",
                                           c, seen_q.size(), exp_t.addr, exp_t.wen, exp_t.wdata, exp_t.wmask);
                    end
                    seen_q.delete();
                    m_busy = 0;
                    if (m_owner) n_lsu++; else n_ifu++;
                end
            end
        end
        n_chk++;
        if (m_busy || n_ifu < 20 || n_lsu < 20) begin
            n_fail++; $display("FAIL rand_progress: busy=%b ifu_done=%0d lsu_done=%0d, expected 0 >=20 >=20",
                               m_busy, n_ifu, n_lsu);
        end
        tick(); idle_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "time limit");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_ifu_read();
        test_lsu_write();
        test_round_robin();
        test_stall();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
